// File: rtl/pcie_c2h_dsc_gen_pkg.sv
// Shared definitions for the C2H bypass-descriptor generator: FSM encoding,
// ring geometry defaults and the fixed descriptor control word.
package pcie_c2h_dsc_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DROP   = 2'd3
   } state_e;

   localparam int unsigned DEF_DATA_W     = 256;
   localparam logic [63:0] DEF_RING_BASE  = 64'h0000_0001_0000_0000;
   localparam int unsigned DEF_NR_SLOTS   = 16;
   localparam int unsigned DEF_SLOT_BYTES = 4096;
   localparam logic [15:0] DSC_CTL        = 16'h0000;

   // Host address of one ring slot.
   function automatic logic [63:0] slot_addr(input logic [63:0] base,
                                             input logic [31:0] idx,
                                             input logic [31:0] slot_bytes);
      return base + (64'(idx) * 64'(slot_bytes));
   endfunction

endpackage

// File: rtl/pcie_c2h_dsc_gen.sv
// C2H descriptor generator: issues one bypass descriptor per host ring slot,
// then streams the packet into XDMA, truncating packets that overflow a slot.
module pcie_c2h_dsc_gen
   import pcie_c2h_dsc_gen_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter logic [63:0] RING_BASE  = DEF_RING_BASE,
   parameter int unsigned NR_SLOTS   = DEF_NR_SLOTS,
   parameter int unsigned SLOT_BYTES = DEF_SLOT_BYTES
) (
   input  logic                          axi_aclk,
   input  logic                          axi_aresetn,
   input  logic [DATA_W-1:0]             s_axis_tdata,
   input  logic [DATA_W/8-1:0]           s_axis_tkeep,
   input  logic                          s_axis_tlast,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [DATA_W-1:0]             m_axis_tdata,
   output logic [DATA_W/8-1:0]           m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [63:0]                   dsc_byp_dst_addr,
   output logic [63:0]                   dsc_byp_src_addr,
   output logic [27:0]                   dsc_byp_len,
   output logic [15:0]                   dsc_byp_ctl,
   input  logic                          dsc_byp_ready,
   output logic                          dsc_byp_load,
   input  logic                          credit_valid,
   input  logic [7:0]                    credit_cnt,
   input  logic                          enable,
   output logic [$clog2(NR_SLOTS)-1:0]   slot_idx,
   output logic [$clog2(NR_SLOTS):0]     credits,
   output logic [31:0]                   pkt_cnt,
   output logic [15:0]                   trunc_cnt,
   output state_e                        dbg_state
);

   localparam int unsigned SLOT_W    = $clog2(NR_SLOTS);
   localparam int unsigned CRED_W    = SLOT_W + 1;
   localparam int unsigned BEATS     = SLOT_BYTES / (DATA_W / 8);
   localparam int unsigned BEAT_W    = $clog2(BEATS + 1);
   localparam logic [9:0]  CRED_MAX  = 10'(NR_SLOTS);
   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(NR_SLOTS);

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   slot_idx_q, slot_idx_d;
   logic [CRED_W-1:0]   credits_q, credits_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [31:0]         pkt_cnt_q, pkt_cnt_d;
   logic [15:0]         trunc_cnt_q, trunc_cnt_d;
   logic                consume;
   logic [9:0]          cred_sum;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q     <= ST_IDLE;
         slot_idx_q  <= '0;
         credits_q   <= CRED_FULL;
         beat_cnt_q  <= '0;
         pkt_cnt_q   <= '0;
         trunc_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         slot_idx_q  <= slot_idx_d;
         credits_q   <= credits_d;
         beat_cnt_q  <= beat_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         trunc_cnt_q <= trunc_cnt_d;
      end
   end

   // Handshakes: a beat or descriptor transfers on the rising edge where its
   // valid (tvalid / dsc_byp_load) and the matching ready are both high.
   always_comb begin
      state_d       = state_q;
      slot_idx_d    = slot_idx_q;
      beat_cnt_d    = beat_cnt_q;
      pkt_cnt_d     = pkt_cnt_q;
      trunc_cnt_d   = trunc_cnt_q;
      consume       = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = s_axis_tlast;
      dsc_byp_load  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && (credits_q != '0) && s_axis_tvalid) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            dsc_byp_load = dsc_byp_ready;
            if (dsc_byp_ready) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            if (s_axis_tvalid && m_axis_tready) begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               if (s_axis_tlast) begin
                  consume    = 1'b1;
                  slot_idx_d = slot_idx_q + SLOT_W'(1);
                  pkt_cnt_d  = pkt_cnt_q + 32'd1;
                  beat_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                  // Slot is full: close it on this beat and discard the rest.
                  m_axis_tlast = 1'b1;
                  consume      = 1'b1;
                  slot_idx_d   = slot_idx_q + SLOT_W'(1);
                  if (trunc_cnt_q != 16'hFFFF) trunc_cnt_d = trunc_cnt_q + 16'd1;
                  beat_cnt_d   = '0;
                  state_d      = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Host returns and local consumption in the same cycle both apply.
      cred_sum  = 10'(credits_q) + (credit_valid ? 10'(credit_cnt) : 10'd0) - 10'(consume);
      credits_d = (cred_sum > CRED_MAX) ? CRED_FULL : cred_sum[CRED_W-1:0];
   end

   assign m_axis_tdata     = s_axis_tdata;
   assign m_axis_tkeep     = s_axis_tkeep;
   assign dsc_byp_dst_addr = slot_addr(RING_BASE, 32'(slot_idx_q), 32'(SLOT_BYTES));
   assign dsc_byp_src_addr = 64'd0;
   assign dsc_byp_len      = 28'(SLOT_BYTES);
   assign dsc_byp_ctl      = DSC_CTL;
   assign slot_idx         = slot_idx_q;
   assign credits          = credits_q;
   assign pkt_cnt          = pkt_cnt_q;
   assign trunc_cnt        = trunc_cnt_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_pcie_c2h_dsc_gen.sv
// Directed bench for pcie_c2h_dsc_gen: ring addressing, credits, descriptor
// back-pressure, slot truncation and mid-packet reset.
module tb_pcie_c2h_dsc_gen;
   import pcie_c2h_dsc_gen_pkg::*;

   localparam int          DATA_W = 256;
   localparam logic [63:0] BASE   = 64'h0000_0001_0000_0000;
   localparam logic [63:0] SB     = 64'h1000;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [DATA_W-1:0]   s_axis_tdata = '0;
   logic [DATA_W/8-1:0] s_axis_tkeep = '1;
   logic                s_axis_tlast = 1'b0;
   logic                s_axis_tvalid = 1'b0;
   logic                s_axis_tready;
   logic [DATA_W-1:0]   m_axis_tdata;
   logic [DATA_W/8-1:0] m_axis_tkeep;
   logic                m_axis_tlast;
   logic                m_axis_tvalid;
   logic                m_axis_tready = 1'b1;
   logic [63:0]         dsc_byp_dst_addr, dsc_byp_src_addr;
   logic [27:0]         dsc_byp_len;
   logic [15:0]         dsc_byp_ctl;
   logic                dsc_byp_ready = 1'b1;
   logic                dsc_byp_load;
   logic                credit_valid = 1'b0;
   logic [7:0]          credit_cnt = '0;
   logic                enable = 1'b0;
   logic [3:0]          slot_idx;
   logic [4:0]          credits;
   logic [31:0]         pkt_cnt;
   logic [15:0]         trunc_cnt;
   state_e              dbg_state;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];
   int load_cnt = 0;
   int beat_out = 0;
   int tlast_out = 0;
   logic [31:0] last_tlast_data = '0;
   int l0, b0, t0;

   pcie_c2h_dsc_gen dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .dsc_byp_dst_addr(dsc_byp_dst_addr), .dsc_byp_src_addr(dsc_byp_src_addr),
      .dsc_byp_len(dsc_byp_len), .dsc_byp_ctl(dsc_byp_ctl),
      .dsc_byp_ready(dsc_byp_ready), .dsc_byp_load(dsc_byp_load),
      .credit_valid(credit_valid), .credit_cnt(credit_cnt), .enable(enable),
      .slot_idx(slot_idx), .credits(credits), .pkt_cnt(pkt_cnt),
      .trunc_cnt(trunc_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor at the falling edge: every descriptor is scored against exp_q.
   always @(negedge clk) begin
      if (dsc_byp_load) begin
         load_cnt++;
         chk("load_needs_ready", 64'(dsc_byp_ready), 64'd1);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_load observed=0x%0h expected=none", dsc_byp_dst_addr);
         end else begin
            chk("dst_addr", dsc_byp_dst_addr, exp_q.pop_front());
         end
         chk("dsc_len", 64'(dsc_byp_len), 64'h1000);
         chk("dsc_src", dsc_byp_src_addr, 64'd0);
         chk("dsc_ctl", 64'(dsc_byp_ctl), 64'd0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
         beat_out++;
         if (m_axis_tlast) begin
            tlast_out++;
            last_tlast_data = m_axis_tdata[31:0];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      credit_valid = 1'b0;
      credit_cnt = '0;
      dsc_byp_ready = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_accept(input string tag);
      bit acc;
      int cyc;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 300) begin
         @(negedge clk);
         acc = s_axis_tready;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!acc) begin
         total++;
         bad++;
         $error("FAIL %s observed=no_tready expected=tready", tag);
      end
   endtask

   task automatic set_beat(input int tag, input int i, input bit last);
      s_axis_tdata = DATA_W'({tag[15:0], i[15:0]});
      s_axis_tlast = last;
      s_axis_tvalid = 1'b1;
   endtask

   task automatic send_pkt(input int n, input int tag);
      for (int i = 0; i < n; i++) begin
         set_beat(tag, i, (i == n - 1));
         wait_accept("beat_accept");
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic credit_pulse(input logic [7:0] cnt);
      credit_valid = 1'b1;
      credit_cnt = cnt;
      tick(1);
      credit_valid = 1'b0;
      credit_cnt = '0;
   endtask

   initial begin
      // Reset values
      rst_n = 1'b0;
      tick(1);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_load", 64'(dsc_byp_load), 64'd0);
      chk("rst_slot", 64'(slot_idx), 64'd0);
      chk("rst_credits", 64'(credits), 64'd16);
      chk("rst_pkt", 64'(pkt_cnt), 64'd0);
      chk("rst_trunc", 64'(trunc_cnt), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // 3-beat packet
      enable = 1'b1;
      exp_q.push_back(BASE);
      send_pkt(3, 16'h0001);
      tick(2);
      chk("p3_loads", 64'(load_cnt), 64'd1);
      chk("p3_beats", 64'(beat_out), 64'd3);
      chk("p3_tlasts", 64'(tlast_out), 64'd1);
      chk("p3_last_data", 64'(last_tlast_data), 64'h0001_0002);
      chk("p3_slot", 64'(slot_idx), 64'd1);
      chk("p3_credits", 64'(credits), 64'd15);
      chk("p3_pkt", 64'(pkt_cnt), 64'd1);

      // 17 single-beat packets with one credit returned after each
      do_reset();
      l0 = load_cnt;
      for (int p = 0; p < 17; p++) begin
         exp_q.push_back(BASE + SB * 64'(p % 16));
         send_pkt(1, 16'h0020 + p);
         credit_pulse(8'd1);
         tick(1);
      end
      chk("wrap_loads", 64'(load_cnt - l0), 64'd17);
      chk("wrap_slot", 64'(slot_idx), 64'd1);
      chk("wrap_credits", 64'(credits), 64'd16);
      chk("wrap_pkt", 64'(pkt_cnt), 64'd17);
      credit_pulse(8'd200);
      chk("credit_sat", 64'(credits), 64'd16);

      // Credit exhaustion stalls the 17th packet
      do_reset();
      l0 = load_cnt;
      for (int p = 0; p < 16; p++) begin
         exp_q.push_back(BASE + SB * 64'(p));
         send_pkt(1, 16'h0040 + p);
      end
      tick(1);
      chk("exh_credits", 64'(credits), 64'd0);
      set_beat(16'h0050, 0, 1'b1);
      tick(5);
      chk("exh_tready", 64'(s_axis_tready), 64'd0);
      chk("exh_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("exh_loads", 64'(load_cnt - l0), 64'd16);
      exp_q.push_back(BASE);
      credit_pulse(8'd1);
      wait_accept("exh_resume");
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      tick(2);
      chk("exh_loads_after", 64'(load_cnt - l0), 64'd17);
      chk("exh_pkt", 64'(pkt_cnt), 64'd17);
      chk("exh_credits_after", 64'(credits), 64'd0);
      chk("exh_slot", 64'(slot_idx), 64'd1);

      // Descriptor back-pressure
      do_reset();
      l0 = load_cnt;
      b0 = beat_out;
      dsc_byp_ready = 1'b0;
      exp_q.push_back(BASE);
      set_beat(16'h0060, 0, 1'b0);
      tick(10);
      chk("bp_loads", 64'(load_cnt - l0), 64'd0);
      chk("bp_beats", 64'(beat_out - b0), 64'd0);
      chk("bp_state", 64'(dbg_state), 64'(ST_LOAD));
      chk("bp_load_now", 64'(dsc_byp_load), 64'd0);
      chk("bp_tready", 64'(s_axis_tready), 64'd0);
      chk("bp_dst_held", dsc_byp_dst_addr, BASE);
      dsc_byp_ready = 1'b1;
      wait_accept("bp_beat0");
      set_beat(16'h0060, 1, 1'b1);
      wait_accept("bp_beat1");
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      tick(2);
      chk("bp_loads_after", 64'(load_cnt - l0), 64'd1);
      chk("bp_beats_after", 64'(beat_out - b0), 64'd2);
      chk("bp_pkt", 64'(pkt_cnt), 64'd1);

      // 130-beat packet overflows a 128-beat slot
      do_reset();
      b0 = beat_out;
      t0 = tlast_out;
      exp_q.push_back(BASE);
      send_pkt(130, 16'h0035);
      tick(2);
      chk("tr_beats", 64'(beat_out - b0), 64'd128);
      chk("tr_tlasts", 64'(tlast_out - t0), 64'd1);
      chk("tr_last_data", 64'(last_tlast_data), 64'h0035_007F);
      chk("tr_trunc", 64'(trunc_cnt), 64'd1);
      chk("tr_slot", 64'(slot_idx), 64'd1);
      chk("tr_credits", 64'(credits), 64'd15);
      chk("tr_state", 64'(dbg_state), 64'(ST_IDLE));
      exp_q.push_back(BASE + SB);
      send_pkt(1, 16'h0036);
      tick(2);
      chk("tr_next_slot", 64'(slot_idx), 64'd2);

      // Reset during the second beat of a 4-beat packet
      do_reset();
      l0 = load_cnt;
      b0 = beat_out;
      exp_q.push_back(BASE);
      send_pkt(1, 16'h0070);
      exp_q.push_back(BASE + SB);
      set_beat(16'h0071, 0, 1'b0);
      wait_accept("rm_beat0");
      set_beat(16'h0071, 1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rm_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rm_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rm_load", 64'(dsc_byp_load), 64'd0);
      chk("rm_slot", 64'(slot_idx), 64'd0);
      chk("rm_credits", 64'(credits), 64'd16);
      chk("rm_pkt", 64'(pkt_cnt), 64'd0);
      chk("rm_state", 64'(dbg_state), 64'(ST_IDLE));
      tick(3);
      chk("rm_beats_in_reset", 64'(beat_out - b0), 64'd2);
      chk("rm_loads_in_reset", 64'(load_cnt - l0), 64'd2);
      s_axis_tvalid = 1'b0;
      rst_n = 1'b1;
      tick(1);
      exp_q.push_back(BASE);
      send_pkt(1, 16'h0072);
      tick(2);
      chk("rm_loads_after", 64'(load_cnt - l0), 64'd3);
      chk("rm_slot_after", 64'(slot_idx), 64'd1);
      chk("rm_pkt_after", 64'(pkt_cnt), 64'd1);

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
